// File: rtl/micromind_seq_checker_pkg.sv
// ============================================================================
// Module   : micromind_pkg
// Brief    : Shared state type and modulo-distance helper for the sequence checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package micromind_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Forward distance from b to a, taken modulo 2^w.
  function automatic logic [31:0] mod_dist(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/micromind_seq_checker_if.sv
// ============================================================================
// Module   : micromind_seq_checker_if
// Brief    : Sample stream and status bundle between a source and the checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface micromind_seq_checker_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_WIDTH = 16
);
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_WIDTH-1:0] err_count;
  logic [WIDTH-1:0]     expected;
  logic [ERR_WIDTH-1:0] miss_count;

  modport master (
    output in_valid, in_data,
    input  locked, err_pulse, err_count, expected, miss_count
  );

  modport slave (
    input  in_valid, in_data,
    output locked, err_pulse, err_count, expected, miss_count
  );
endinterface

`default_nettype wire

// File: rtl/micromind_seq_checker_sat_counter.sv
// ============================================================================
// Module   : micromind_sat_counter
// Brief    : Accumulator that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module micromind_sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             clear,
  input  wire logic             inc,
  input  wire logic [WIDTH-1:0] inc_val,
  output logic      [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_value} + {1'b0, inc_val};
  assign value = r_value;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/micromind_seq_checker.sv
// ============================================================================
// Module   : micromind_seq_checker
// Brief    : Locks onto a +1 modulo count stream and tallies discontinuities.
//            Optional skipped-value accumulator: MICROMIND_SEQ_CHK_MISS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module micromind_seq_checker
  import micromind_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ERR_WIDTH  = 16,
  parameter int LOCK_COUNT = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              clear,
  micromind_seq_checker_if.slave bus
);

  localparam logic [7:0] c_LOCK_CNT = 8'(LOCK_COUNT);

  state_t           r_state;
  logic             r_locked;
  logic             r_err_pulse;
  logic [WIDTH-1:0] r_expected;
  logic [7:0]       r_match;

  logic             w_match;
  logic [7:0]       w_match_nxt;
  logic             w_lock_err;
  logic [ERR_WIDTH-1:0] w_err_count;

  assign w_match     = (bus.in_data == r_expected);
  assign w_match_nxt = r_match + 8'd1;
  assign w_lock_err  = bus.in_valid && (r_state == ST_LOCKED) && !w_match;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state     <= ST_IDLE;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_expected  <= '0;
      r_match     <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (bus.in_valid) begin
        unique case (r_state)
          ST_IDLE: begin
            r_expected <= bus.in_data + WIDTH'(1);
            r_match    <= 8'd1;
            if (c_LOCK_CNT == 8'd1) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state  <= ST_ACQUIRE;
            end
          end
          ST_ACQUIRE: begin
            if (w_match) begin
              r_expected <= r_expected + WIDTH'(1);
              r_match    <= w_match_nxt;
              if (w_match_nxt >= c_LOCK_CNT) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              // Resynchronise silently; errors only count once locked.
              r_expected <= bus.in_data + WIDTH'(1);
              r_match    <= 8'd1;
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_expected <= r_expected + WIDTH'(1);
            end else begin
              r_err_pulse <= 1'b1;
              r_state     <= ST_ACQUIRE;
              r_locked    <= 1'b0;
              r_expected  <= bus.in_data + WIDTH'(1);
              r_match     <= 8'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  micromind_sat_counter #(
    .WIDTH   (ERR_WIDTH)
  ) u_err_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .inc     (w_lock_err),
    .inc_val (ERR_WIDTH'(1)),
    .value   (w_err_count)
  );

`ifdef MICROMIND_SEQ_CHK_MISS_EN
  localparam logic [31:0] c_ERR_MAX = (ERR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << ERR_WIDTH) - 32'd1);
  logic [31:0]          w_dist;
  logic [ERR_WIDTH-1:0] w_miss_inc;
  logic [ERR_WIDTH-1:0] w_miss_count;

  // Clamp first so a narrow accumulator still saturates on one big jump.
  assign w_dist     = mod_dist(32'(bus.in_data), 32'(r_expected), WIDTH);
  assign w_miss_inc = (w_dist > c_ERR_MAX) ? '1 : ERR_WIDTH'(w_dist);

  micromind_sat_counter #(
    .WIDTH   (ERR_WIDTH)
  ) u_miss_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .inc     (w_lock_err),
    .inc_val (w_miss_inc),
    .value   (w_miss_count)
  );

  assign bus.miss_count = w_miss_count;
`else
  assign bus.miss_count = '0;
`endif

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_count = w_err_count;
  assign bus.expected  = r_expected;

endmodule

`default_nettype wire

// File: tb/tb_micromind_seq_checker.sv
// ============================================================================
// Module   : tb_micromind_seq_checker
// Brief    : Directed and random checks of two checker instances (16-bit and
//            2-bit error counters) against a stream-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_micromind_seq_checker;

  localparam int LOCK = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       v     = 1'b0;
  logic [7:0] d     = 8'd0;

  int n_checks = 0;
  int n_err    = 0;
  string phase = "reset";

  // Reference model: a "run" is the number of consecutive in-sequence samples
  // since the stream was last (re)acquired.
  bit     m_active;
  bit     m_locked;
  bit     m_pulse;
  int     m_exp;
  int     m_run;
  longint m_errs;
  longint m_miss;

  micromind_seq_checker_if #(.WIDTH(8), .ERR_WIDTH(16)) if_a ();
  micromind_seq_checker_if #(.WIDTH(8), .ERR_WIDTH(2))  if_b ();

  assign if_a.in_valid = v;
  assign if_a.in_data  = d;
  assign if_b.in_valid = v;
  assign if_b.in_data  = d;

  micromind_seq_checker #(.WIDTH(8), .ERR_WIDTH(16), .LOCK_COUNT(LOCK)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .bus(if_a.slave)
  );
  micromind_seq_checker #(.WIDTH(8), .ERR_WIDTH(2), .LOCK_COUNT(LOCK)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .bus(if_b.slave)
  );

  always #5 clk = ~clk;

  function automatic longint sat(input longint x, input longint mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit vv, input logic [7:0] dd, input bit clr);
    m_pulse = 1'b0;
    if (clr) begin
      m_active = 1'b0; m_locked = 1'b0; m_exp = 0; m_run = 0;
      m_errs = 0; m_miss = 0;
    end else if (vv) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_run    = 1;
        m_exp    = (int'(dd) + 1) % 256;
        m_locked = (m_run >= LOCK);
      end else if (int'(dd) == m_exp) begin
        m_exp = (m_exp + 1) % 256;
        if (!m_locked) begin
          m_run++;
          if (m_run >= LOCK) m_locked = 1'b1;
        end
      end else begin
        if (m_locked) begin
          m_pulse = 1'b1;
          m_errs++;
          m_miss += (int'(dd) - m_exp + 256) % 256;
        end
        m_locked = 1'b0;
        m_run    = 1;
        m_exp    = (int'(dd) + 1) % 256;
      end
    end
  endtask

  task automatic check_all();
    longint exp_miss_a, exp_miss_b;
`ifdef MICROMIND_SEQ_CHK_MISS_EN
    exp_miss_a = sat(m_miss, 65535);
    exp_miss_b = sat(m_miss, 3);
`else
    exp_miss_a = 0;
    exp_miss_b = 0;
`endif
    chk("locked",    64'(if_a.locked),     64'(m_locked));
    chk("err_pulse", 64'(if_a.err_pulse),  64'(m_pulse));
    chk("expected",  64'(if_a.expected),   64'(m_exp));
    chk("err_cnt16", 64'(if_a.err_count),  64'(sat(m_errs, 65535)));
    chk("err_cnt2",  64'(if_b.err_count),  64'(sat(m_errs, 3)));
    chk("miss16",    64'(if_a.miss_count), 64'(exp_miss_a));
    chk("miss2",     64'(if_b.miss_count), 64'(exp_miss_b));
    chk("b_locked",  64'(if_b.locked),     64'(m_locked));
  endtask

  task automatic step(input bit vv, input logic [7:0] dd, input bit cc = 1'b0, input bit rr = 1'b0);
    v = vv; d = dd; clear = cc; reset = rr;
    @(posedge clk);
    #1;
    model_step(vv, dd, cc | rr);
    check_all();
  endtask

  initial begin
    // Reset, with a valid mismatched sample that must be discarded.
    step(1'b1, 8'd99, 1'b0, 1'b1);
    step(1'b0, 8'd0,  1'b0, 1'b1);
    chk("rst_locked",   64'(if_a.locked),    64'd0);
    chk("rst_expected", 64'(if_a.expected),  64'd0);
    chk("rst_errcnt",   64'(if_a.err_count), 64'd0);

    phase = "lock";
    for (int i = 10; i <= 13; i++) step(1'b1, 8'(i));
    chk("locked_after_13", 64'(if_a.locked),    64'd1);
    chk("expected_14",     64'(if_a.expected),  64'd14);
    chk("errcnt_0",        64'(if_a.err_count), 64'd0);

    phase = "error";
    for (int i = 14; i <= 19; i++) step(1'b1, 8'(i));
    step(1'b1, 8'd25);
    chk("pulse",    64'(if_a.err_pulse), 64'd1);
    chk("errcnt_1", 64'(if_a.err_count), 64'd1);
    chk("unlocked", 64'(if_a.locked),    64'd0);
    chk("exp_26",   64'(if_a.expected),  64'd26);
`ifdef MICROMIND_SEQ_CHK_MISS_EN
    chk("miss_5",   64'(if_a.miss_count), 64'd5);
`endif
    step(1'b1, 8'd26);
    chk("pulse_one_cycle", 64'(if_a.err_pulse), 64'd0);
    step(1'b1, 8'd27);
    step(1'b1, 8'd28);
    chk("relocked", 64'(if_a.locked), 64'd1);

    phase = "wrap";
    for (int i = 250; i <= 253; i++) step(1'b1, 8'(i));
    chk("locked_253", 64'(if_a.locked), 64'd1);
    step(1'b1, 8'd254);
    step(1'b1, 8'd255);
    step(1'b1, 8'd0);
    step(1'b1, 8'd1);
    chk("locked_wrap", 64'(if_a.locked),    64'd1);
    chk("exp_2",       64'(if_a.expected),  64'd2);
    chk("errcnt_2",    64'(if_a.err_count), 64'd2);

    phase = "gaps";
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd40);
    step(1'b1, 8'd41);
    for (int i = 0; i < 7; i++) step(1'b0, 8'($urandom_range(0, 255)));
    step(1'b1, 8'd42);
    step(1'b1, 8'd43);
    chk("locked_gaps", 64'(if_a.locked),    64'd1);
    chk("no_err_gaps", 64'(if_a.err_count), 64'd0);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      bit         rv;
      bit         rc;
      logic [7:0] rd;
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 63) == 0);
      rd = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(0, 255)) : 8'(m_exp);
      step(rv, rd, rc);
    end

    phase = "saturate";
    step(1'b0, 8'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) step(1'b1, 8'(100 + 16 * k + j));
      step(1'b1, 8'(100 + 16 * k + 8));
    end
    chk("errcnt2_sat", 64'(if_b.err_count), 64'd3);
    chk("errcnt16_5",  64'(if_a.err_count), 64'd5);

    phase = "clear_prio";
    for (int i = 200; i <= 203; i++) step(1'b1, 8'(i));
    chk("locked_pre", 64'(if_a.locked), 64'd1);
    step(1'b1, 8'd77, 1'b1);
    chk("no_pulse",   64'(if_a.err_pulse), 64'd0);
    chk("idle_lock",  64'(if_a.locked),    64'd0);
    chk("idle_err",   64'(if_a.err_count), 64'd0);
    chk("idle_exp",   64'(if_a.expected),  64'd0);
    step(1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/micromind_seq_checker.md
# micromind_seq_checker

Sequence checker for the free-running `micromind` count stream. It samples a WIDTH-bit count value on each valid cycle and locks onto the +1 modulo-2^WIDTH sequence. Once locked, it flags every discontinuity and keeps a saturating error tally. It sits at the receiving end of any path that carries a `micromind` counter value, such as a CDC crossing, serializer loopback or bus, and serves as the integrity monitor for that path.

## Interface
- WIDTH, 8: width of the monitored count value.
- ERR_WIDTH, 16: width of the error counter.
- LOCK_COUNT, 4: consecutive in-sequence samples required to declare lock (≥1, < 2^8).
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear: same effect as reset on state and counters.
- in_valid  input  1  in_data carries a sample this cycle.
- in_data  input  WIDTH  sampled count value.
- locked  output  1  checker is in LOCKED state.
- err_pulse  output  1  one-cycle pulse per sequence error detected while locked.
- err_count  output  ERR_WIDTH  saturating count of errors since reset/clear.
- expected  output  WIDTH  next value the checker expects.
- miss_count  output  ERR_WIDTH  saturating total of skipped values (only with MICROMIND_SEQ_CHK_MISS_EN).

## Operation
- States: IDLE, ACQUIRE, LOCKED. All outputs are registered.
- Reset values: state IDLE, locked 0, err_pulse 0, err_count 0, expected 0, miss_count 0, match counter 0.
- IDLE, on in_valid: expected ← in_data+1, match counter ← 1, go to ACQUIRE. If LOCK_COUNT==1, go directly to LOCKED.
- ACQUIRE, on in_valid:
  - in_data==expected: match counter+1, expected+1. When the counter reaches LOCK_COUNT, go to LOCKED.
  - Mismatch: resync with expected ← in_data+1 and match counter ← 1. No error is flagged.
- LOCKED, on in_valid:
  - Match: expected+1.
  - Mismatch: err_pulse=1 next cycle, err_count+1 (saturates at all-ones), expected ← in_data+1, match counter ← 1, go to ACQUIRE.
- in_valid=0: no state, expected or counter change. Gaps in valid are not errors.
- Arithmetic is modulo 2^WIDTH. After 2^WIDTH−1 the expected value is 0, and that wrap is in-sequence.
- A repeated value (in_data==expected−1) counts as a mismatch.
- Priority: reset > clear > sample. With clear and in_valid in the same cycle, the sample is discarded and the block enters IDLE.
- Reset or clear mid-acquire or mid-lock: the next cycle shows IDLE with all outputs at reset values. Any err_pulse that would have fired is suppressed.

## Timing
- Sample at edge N; locked, expected, err_pulse and err_count update at edge N+1 (1-cycle latency).
- err_pulse is high for exactly one cycle per error. Back-to-back errors cannot occur, because an error forces ACQUIRE.
- Minimum time to lock from IDLE: LOCK_COUNT valid samples. locked rises one cycle after the LOCK_COUNT-th sample.
- locked falls one cycle after the offending sample, in the same cycle err_pulse is high.
- No combinational path from inputs to outputs.

## Configuration
- MICROMIND_SEQ_CHK_MISS_EN defined:
  - On each LOCKED mismatch, miss_count += (in_data − expected) mod 2^WIDTH, saturating at all-ones.
  - A repeat or backward step adds the modulo distance; no special case.
- Not defined: the miss_count port still exists, is tied to 0, and no accumulator logic is built.

## Structure
- micromind_pkg holds:
  - the state typedef (IDLE/ACQUIRE/LOCKED);
  - the helper function for modulo-2^WIDTH distance.
- Sub-module micromind_sat_counter (parameter WIDTH; inputs clk, reset, clear, inc, inc_val; output saturating value). It is instantiated for err_count, and for miss_count when enabled.

## Test plan
- Lock: after reset, drive 10,11,12,13 with in_valid=1 and LOCK_COUNT=4 → locked=1 one cycle after 13, expected=14, err_count=0.
- Wrap: when locked, drive 254,255,0,1 with WIDTH=8 → locked stays 1, no err_pulse, expected=2.
- Error: when locked with expected=20, drive 25 → err_pulse for one cycle, err_count=1, locked=0, expected=26. Drive 26,27,28 → locked=1 again. With MICROMIND_SEQ_CHK_MISS_EN, miss_count=5.
- Valid gaps: drive 40,41 then in_valid=0 for 7 cycles, then 42,43 → locks, no error.
- Saturation: ERR_WIDTH=2, force 5 lock/error cycles → err_count holds at 3.
- Clear priority: assert clear with in_valid=1 and in_data mismatched while locked → no err_pulse, next cycle IDLE with locked=0, err_count=0, expected=0.
